// File: rtl/exc_sequencer_pkg.sv
// Shared encodings for the exception entry sequencer: FSM states, ExcCodes,
// cause-word field positions and the default handler vector.
package exc_sequencer_pkg;

    typedef enum logic [2:0] {
        StRun    = 3'd0,
        StFlush  = 3'd1,
        StCommit = 3'd2,
        StRedir  = 3'd3,
        StEret   = 3'd4
    } excStateE;

    localparam logic [4:0] ExcInt  = 5'd0;
    localparam logic [4:0] ExcAdEL = 5'd4;
    localparam logic [4:0] ExcAdES = 5'd5;
    localparam logic [4:0] ExcRI   = 5'd10;
    localparam logic [4:0] ExcOv   = 5'd12;

    localparam int unsigned CauseBdBit = 31;
    localparam int unsigned CauseExcHi = 6;
    localparam int unsigned CauseExcLo = 2;

    localparam logic [31:0] DefaultExcVector = 32'h0000_4180;

    // A delay-slot instruction reports the branch as its restart point.
    function automatic logic [31:0] restartPc(input logic [31:0] pc, input logic bd);
        return bd ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/exc_prio_decode.sv
// Combinational arbitration of interrupt / exception / eret for the M-stage
// instruction, plus the EPC, ExcCode and BD values to latch on entry.
module exc_prio_decode
    import exc_sequencer_pkg::*;
(
    input  logic        validM,
    input  logic [31:0] causeM,
    input  logic [31:0] pcM,
    input  logic        eretM,
    input  logic [5:0]  hwInt,
    input  logic [5:0]  srIm,
    input  logic        srIe,
    input  logic        srExl,
    output logic        intReq,
    output logic        excReq,
    output logic        eretReq,
    output logic [31:0] epc,
    output logic [4:0]  code,
    output logic        bd
);

    assign intReq  = validM & (|(hwInt & srIm)) & srIe & ~srExl;
    assign excReq  = validM & (causeM[30:0] != 31'd0);
    assign eretReq = validM & eretM & ~excReq & ~intReq;

    assign bd   = causeM[CauseBdBit];
    assign epc  = restartPc(pcM, causeM[CauseBdBit]);
    // The interrupt wins over a simultaneous exception; that instruction is flushed.
    assign code = intReq ? ExcInt : causeM[CauseExcHi:CauseExcLo];

endmodule

// File: rtl/exc_sequencer.sv
// Exception/interrupt entry sequencer: flush -> CP0 commit -> redirect, or
// flush+redirect for eret. Define EXC_MDU_WAIT_EN to hold FLUSH while md_busy.
module exc_sequencer
    import exc_sequencer_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = DefaultExcVector,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        validM,
    input  logic [31:0] causeM,
    input  logic [31:0] pcM,
    input  logic        eretM,
    input  logic [5:0]  hw_int,
    input  logic [5:0]  sr_im,
    input  logic        sr_ie,
    input  logic        sr_exl,
    input  logic [31:0] epc_in,
    input  logic        md_busy,
    output logic        kill_m,
    output logic        flush,
    output logic        busy,
    output logic        cp0_exc_we,
    output logic [31:0] cp0_epc,
    output logic [4:0]  cp0_exccode,
    output logic        cp0_bd,
    output logic        cp0_exl_clr,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc
);

    localparam logic [3:0] FlushLast = 4'(FLUSH_CYCLES - 1);

    excStateE    stateQ, stateD;
    logic [3:0]  cntQ, cntD;
    logic [31:0] epcQ, epcD;
    logic [4:0]  codeQ, codeD;
    logic        bdQ, bdD;

    logic        intReq, excReq, eretReq;
    logic [31:0] evEpc;
    logic [4:0]  evCode;
    logic        evBd;

    logic        flushD, busyD, excWeD, exlClrD, redirD, cp0BdD;
    logic [31:0] cp0EpcD, redirPcD;
    logic [4:0]  cp0CodeD;

    exc_prio_decode uDecode (
        .validM  (validM),
        .causeM  (causeM),
        .pcM     (pcM),
        .eretM   (eretM),
        .hwInt   (hw_int),
        .srIm    (sr_im),
        .srIe    (sr_ie),
        .srExl   (sr_exl),
        .intReq  (intReq),
        .excReq  (excReq),
        .eretReq (eretReq),
        .epc     (evEpc),
        .code    (evCode),
        .bd      (evBd)
    );

    assign kill_m = (stateQ == StRun) & (intReq | excReq);

`ifndef EXC_MDU_WAIT_EN
    logic unusedMdBusy;
    assign unusedMdBusy = md_busy;
`endif

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        epcD   = epcQ;
        codeD  = codeQ;
        bdD    = bdQ;
        case (stateQ)
            StRun: begin
                cntD = 4'd0;
                if (intReq | excReq) begin
                    stateD = StFlush;
                    epcD   = evEpc;
                    codeD  = evCode;
                    bdD    = evBd;
                end else if (eretReq) begin
                    stateD = StEret;
                end
            end
            StFlush: begin
                if (cntQ == FlushLast) begin
`ifdef EXC_MDU_WAIT_EN
                    // Counter saturates here until the mult/div unit drains.
                    if (!md_busy) begin
                        stateD = StCommit;
                        cntD   = 4'd0;
                    end
`else
                    stateD = StCommit;
                    cntD   = 4'd0;
`endif
                end else begin
                    cntD = cntQ + 4'd1;
                end
            end
            StCommit: stateD = StRedir;
            StRedir:  stateD = StRun;
            StEret:   stateD = StRun;
            default:  stateD = StRun;
        endcase
    end

    // Outputs are registered: decode them from the next state.
    always_comb begin
        flushD   = (stateD == StFlush) | (stateD == StCommit) | (stateD == StEret);
        busyD    = (stateD != StRun);
        excWeD   = (stateD == StCommit);
        exlClrD  = (stateD == StEret);
        redirD   = (stateD == StRedir) | (stateD == StEret);
        cp0EpcD  = 32'd0;
        cp0CodeD = 5'd0;
        cp0BdD   = 1'b0;
        redirPcD = 32'd0;
        if (stateD == StCommit) begin
            cp0EpcD  = epcQ;
            cp0CodeD = codeQ;
            cp0BdD   = bdQ;
        end
        if (stateD == StRedir) begin
            redirPcD = EXC_VECTOR;
        end else if (stateD == StEret) begin
            redirPcD = epc_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ      <= StRun;
            cntQ        <= 4'd0;
            epcQ        <= 32'd0;
            codeQ       <= 5'd0;
            bdQ         <= 1'b0;
            flush       <= 1'b0;
            busy        <= 1'b0;
            cp0_exc_we  <= 1'b0;
            cp0_epc     <= 32'd0;
            cp0_exccode <= 5'd0;
            cp0_bd      <= 1'b0;
            cp0_exl_clr <= 1'b0;
            pc_redirect <= 1'b0;
            redirect_pc <= 32'd0;
        end else begin
            stateQ      <= stateD;
            cntQ        <= cntD;
            epcQ        <= epcD;
            codeQ       <= codeD;
            bdQ         <= bdD;
            flush       <= flushD;
            busy        <= busyD;
            cp0_exc_we  <= excWeD;
            cp0_epc     <= cp0EpcD;
            cp0_exccode <= cp0CodeD;
            cp0_bd      <= cp0BdD;
            cp0_exl_clr <= exlClrD;
            pc_redirect <= redirD;
            redirect_pc <= redirPcD;
        end
    end

endmodule

// File: tb/tb_exc_sequencer.sv
// Randomized scoreboard bench for exc_sequencer; honours EXC_MDU_WAIT_EN.
module tb_exc_sequencer;

    localparam logic [31:0] Vec   = 32'h0000_4180;
    localparam int unsigned Flush = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        validM, eretM, sr_ie, sr_exl, md_busy;
    logic [31:0] causeM, pcM, epc_in;
    logic [5:0]  hw_int, sr_im;
    logic        kill_m, flush, busy, cp0_exc_we, cp0_bd, cp0_exl_clr, pc_redirect;
    logic [31:0] cp0_epc, redirect_pc;
    logic [4:0]  cp0_exccode;

    exc_sequencer #(
        .EXC_VECTOR   (Vec),
        .FLUSH_CYCLES (Flush)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .validM      (validM),
        .causeM      (causeM),
        .pcM         (pcM),
        .eretM       (eretM),
        .hw_int      (hw_int),
        .sr_im       (sr_im),
        .sr_ie       (sr_ie),
        .sr_exl      (sr_exl),
        .epc_in      (epc_in),
        .md_busy     (md_busy),
        .kill_m      (kill_m),
        .flush       (flush),
        .busy        (busy),
        .cp0_exc_we  (cp0_exc_we),
        .cp0_epc     (cp0_epc),
        .cp0_exccode (cp0_exccode),
        .cp0_bd      (cp0_bd),
        .cp0_exl_clr (cp0_exl_clr),
        .pc_redirect (pc_redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] cause;
        logic [31:0] pc;
        logic        eret;
        logic [5:0]  hw;
        logic [5:0]  im;
        logic        ie;
        logic        exl;
        logic [31:0] epcIn;
        logic        mdb;
    } stimT;

    typedef struct {
        bit          isEret;
        logic [31:0] epc;
        logic [4:0]  code;
        logic        bd;
        logic [31:0] target;
    } expT;

    expT sbQ[$];
    int  checks = 0;
    int  errors = 0;

    // Reference position: kind of event in progress and cycles since its edge.
    int  evKind = 0;   // 0 none, 1 exception/interrupt, 2 eret
    int  evAge = 0;
    int  flushLen = 0;
    int  flushSeen = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic stimT idleStim();
        stimT s;
        s.v = 0; s.cause = 0; s.pc = 0; s.eret = 0; s.hw = 0; s.im = 0;
        s.ie = 0; s.exl = 0; s.epcIn = 0; s.mdb = 0;
        return s;
    endfunction

    task automatic checkAllZero(input string tag);
        chk({tag, "_flush"}, 32'(flush), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_we"}, 32'(cp0_exc_we), 0);
        chk({tag, "_epc"}, cp0_epc, 0);
        chk({tag, "_code"}, 32'(cp0_exccode), 0);
        chk({tag, "_bd"}, 32'(cp0_bd), 0);
        chk({tag, "_exlclr"}, 32'(cp0_exl_clr), 0);
        chk({tag, "_redir"}, 32'(pc_redirect), 0);
        chk({tag, "_redirpc"}, redirect_pc, 0);
        chk({tag, "_kill"}, 32'(kill_m), 0);
    endtask

    // One clock: check registered outputs for the current position, drive
    // inputs, check kill_m, then update the reference model.
    task automatic stepCycle(input stimT s);
        bit  intR, excR, ertR, expBusy, expFlush, expWe, expRedir, expClr;
        expT e;
        @(negedge clk);
        expBusy  = (evKind != 0);
        expFlush = (evKind == 1 && evAge <= flushLen + 1) || (evKind == 2);
        expWe    = (evKind == 1 && evAge == flushLen + 1);
        expRedir = (evKind == 1 && evAge == flushLen + 2) || (evKind == 2);
        expClr   = (evKind == 2);
        chk("busy", 32'(busy), 32'(expBusy));
        chk("flush", 32'(flush), 32'(expFlush));
        chk("cp0_exc_we_timing", 32'(cp0_exc_we), 32'(expWe));
        chk("pc_redirect_timing", 32'(pc_redirect), 32'(expRedir));
        chk("cp0_exl_clr_timing", 32'(cp0_exl_clr), 32'(expClr));
        if (flush && busy && !cp0_exc_we && !pc_redirect) flushSeen++;

        validM = s.v; causeM = s.cause; pcM = s.pc; eretM = s.eret; hw_int = s.hw;
        sr_im = s.im; sr_ie = s.ie; sr_exl = s.exl; epc_in = s.epcIn; md_busy = s.mdb;
        #1;
        intR = s.v && ((s.hw & s.im) != 0) && s.ie && !s.exl;
        excR = s.v && (s.cause[30:0] != 0);
        ertR = s.v && s.eret && !intR && !excR;
        chk("kill_m", 32'(kill_m), 32'((evKind == 0) && (intR || excR)));
        if (evKind == 0 && (intR || excR)) begin
            e.isEret = 0;
            e.bd     = s.cause[31];
            e.epc    = s.cause[31] ? s.pc - 32'd4 : s.pc;
            e.code   = intR ? 5'd0 : s.cause[6:2];
            e.target = Vec;
            sbQ.push_back(e);
            evKind = 1; evAge = 0; flushLen = Flush;
        end else if (evKind == 0 && ertR) begin
            e.isEret = 1; e.bd = 0; e.epc = 0; e.code = 0; e.target = s.epcIn;
            sbQ.push_back(e);
            evKind = 2; evAge = 0;
        end
`ifdef EXC_MDU_WAIT_EN
        if (evKind == 1 && evAge >= 1 && evAge == flushLen && s.mdb) flushLen++;
`endif
        @(posedge clk);
        if (evKind != 0) begin
            evAge++;
            if ((evKind == 1 && evAge > flushLen + 2) || (evKind == 2 && evAge > 1))
                evKind = 0;
        end
    endtask

    // Monitor: compare CP0 and redirect payloads against the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            chk("strobes_exclusive", 32'(cp0_exc_we & cp0_exl_clr), 0);
            if (cp0_exc_we) begin
                chk("we_expected", 32'(sbQ.size() != 0 && !sbQ[0].isEret), 1);
                if (sbQ.size() != 0) begin
                    chk("cp0_epc", cp0_epc, sbQ[0].epc);
                    chk("cp0_exccode", 32'(cp0_exccode), 32'(sbQ[0].code));
                    chk("cp0_bd", 32'(cp0_bd), 32'(sbQ[0].bd));
                end
            end
            if (pc_redirect) begin
                chk("redirect_expected", 32'(sbQ.size() != 0), 1);
                if (sbQ.size() != 0) begin
                    expT e;
                    e = sbQ.pop_front();
                    chk("redirect_pc", redirect_pc, e.target);
                    chk("redirect_exlclr", 32'(cp0_exl_clr), 32'(e.isEret));
                end
            end
        end
    end

    stimT s;
    stimT idle;
    logic [4:0] codes [4];

    initial begin
        codes[0] = 5'd4; codes[1] = 5'd5; codes[2] = 5'd10; codes[3] = 5'd12;
        idle = idleStim();
        validM = 0; causeM = 0; pcM = 0; eretM = 0; hw_int = 0; sr_im = 0;
        sr_ie = 0; sr_exl = 0; epc_in = 0; md_busy = 0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        reset = 1;

        // RI exception
        s = idle; s.v = 1; s.cause = 32'h0000_0028; s.pc = 32'h3010;
        stepCycle(s); repeat (4) stepCycle(idle);
        // Delay-slot interrupt
        s = idle; s.v = 1; s.cause = 32'h8000_0000; s.pc = 32'h3020;
        s.hw = 6'b000100; s.im = 6'b000100; s.ie = 1;
        stepCycle(s); repeat (4) stepCycle(idle);
        // Interrupt together with Ov
        s.cause = 32'h0000_0030; s.pc = 32'h3030;
        stepCycle(s); repeat (4) stepCycle(idle);
        // eret
        s = idle; s.v = 1; s.eret = 1; s.epcIn = 32'h3040;
        stepCycle(s); repeat (2) stepCycle(idle);
        // EXL masks a pending interrupt
        s = idle; s.v = 1; s.hw = 6'h3f; s.im = 6'h3f; s.ie = 1; s.exl = 1;
        stepCycle(s); stepCycle(idle);
        // Exception arriving while in FLUSH is ignored
        s = idle; s.v = 1; s.cause = 32'h0000_0010; s.pc = 32'h3060;
        stepCycle(s);
        s.cause = 32'h0000_0014; s.pc = 32'h3064;
        stepCycle(s); repeat (4) stepCycle(idle);
        // pcM=0 in a delay slot wraps
        s = idle; s.v = 1; s.cause = 32'h8000_0028; s.pc = 32'h0;
        stepCycle(s); repeat (4) stepCycle(idle);

        // md_busy held high across the first FLUSH cycles
        flushSeen = 0;
        s = idle; s.v = 1; s.cause = 32'h0000_0028; s.pc = 32'h3070; s.mdb = 1;
        stepCycle(s);
        s = idle; s.mdb = 1;
        repeat (4) stepCycle(s);
        repeat (6) stepCycle(idle);
`ifdef EXC_MDU_WAIT_EN
        chk("mdu_flush_len", 32'(flushSeen), 5);
`else
        chk("mdu_flush_len", 32'(flushSeen), 1);
`endif

        // Reset pulled low while in COMMIT
        s = idle; s.v = 1; s.cause = 32'h0000_0028; s.pc = 32'h3080;
        stepCycle(s);
        repeat (Flush) stepCycle(idle);
        @(negedge clk);
        chk("commit_before_reset", 32'(cp0_exc_we), 1);
        reset = 0;
        #1;
        checkAllZero("reset_in_commit");
        sbQ.delete();
        evKind = 0;
        repeat (2) @(negedge clk);
        reset = 1;
        repeat (4) stepCycle(idle);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            s = idle;
            s.v = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: s.cause = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h0;
                default: s.cause = {1'($urandom_range(0, 1)), 24'd0,
                                    codes[$urandom_range(0, 3)], 2'b00};
            endcase
            if ($urandom_range(0, 2) == 0) s.cause = 32'h0;
            s.pc    = $urandom;
            s.eret  = ($urandom_range(0, 3) == 0);
            s.hw    = 6'($urandom);
            s.im    = 6'($urandom);
            s.ie    = ($urandom_range(0, 3) == 0);
            s.exl   = ($urandom_range(0, 1) != 0);
            s.epcIn = $urandom;
            s.mdb   = ($urandom_range(0, 2) == 0);
            stepCycle(s);
        end
        repeat (24) stepCycle(idle);
        chk("scoreboard_drained", 32'(sbQ.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
